// File: rtl/cache_read_responder_pkg.sv
// Shared widths, FSM encoding and legal byte-enable patterns for the cache read responder.
package cache_read_responder_pkg;

    localparam int unsigned CpuDataSize    = 32;
    localparam int unsigned RamDataSize    = 4 * CpuDataSize;
    localparam int unsigned BValSize       = 4;
    localparam int unsigned AddrOffsetSize = 4;
    localparam int unsigned TimeoutCycles  = 64;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitRam = 2'd1,
        StResp    = 2'd2
    } state_e;

    localparam logic [BValSize-1:0] BValByte0 = 4'b0001;
    localparam logic [BValSize-1:0] BValByte1 = 4'b0010;
    localparam logic [BValSize-1:0] BValByte2 = 4'b0100;
    localparam logic [BValSize-1:0] BValByte3 = 4'b1000;
    localparam logic [BValSize-1:0] BValHalf0 = 4'b0011;
    localparam logic [BValSize-1:0] BValHalf1 = 4'b1100;
    localparam logic [BValSize-1:0] BValWord  = 4'b1111;

    function automatic logic b_val_legal(input logic [BValSize-1:0] b_val);
        logic legal;
        case (b_val)
            BValByte0, BValByte1, BValByte2, BValByte3,
            BValHalf0, BValHalf1, BValWord: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/cache_read_responder_read_word_mask.sv
// Selects one CPU word from a cache line and zeroes byte lanes not enabled by b_val.
module cache_read_responder_read_word_mask
    import cache_read_responder_pkg::*;
(
    input  logic [RamDataSize-1:0] line,
    input  logic [1:0]             word_idx,
    input  logic [BValSize-1:0]    b_val,
    output logic [CpuDataSize-1:0] word,
    output logic                   err
);

    logic [CpuDataSize-1:0] word_sel;
    logic [CpuDataSize-1:0] word_masked;

    always_comb begin
        word_sel    = line[int'(word_idx) * CpuDataSize +: CpuDataSize];
        word_masked = '0;
        for (int k = 0; k < BValSize; k++) begin
            word_masked[8*k +: 8] = word_sel[8*k +: 8] & {8{b_val[k]}};
        end
        err  = ~b_val_legal(b_val);
        word = err ? '0 : word_masked;
    end

endmodule

// File: rtl/cache_read_responder.sv
// Returns one masked CPU word from a cache line, fetching the line from RAM on a miss
// and pulsing a fill strobe so the line can be written back into the cache.
module cache_read_responder
    import cache_read_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCycles
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      IN_REQ_VALID,
    output logic                      OUT_REQ_READY,
    input  logic                      IN_HIT,
    input  logic [AddrOffsetSize-1:0] IN_ADDR_OFFSET,
    input  logic [BValSize-1:0]       IN_B_VAL,
    input  logic [RamDataSize-1:0]    IN_CACHE_DATA,
    output logic                      OUT_RAM_REQ,
    input  logic                      IN_RAM_VALID,
    input  logic [RamDataSize-1:0]    IN_RAM_DATA,
    output logic                      OUT_FILL_VALID,
    output logic [RamDataSize-1:0]    OUT_FILL_DATA,
    output logic                      OUT_RESP_VALID,
    input  logic                      IN_RESP_READY,
    output logic [CpuDataSize-1:0]    OUT_RESP_DATA,
    output logic                      OUT_RESP_ERR
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    state_e                 state_q, state_d;
    logic [RamDataSize-1:0] line_q, line_d;
    logic [RamDataSize-1:0] fill_data_q, fill_data_d;
    logic                   fill_valid_q, fill_valid_d;
    logic [1:0]             idx_q, idx_d;
    logic [BValSize-1:0]    b_val_q, b_val_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CpuDataSize-1:0] resp_data_q, resp_data_d;
    logic                   resp_err_q, resp_err_d;

    logic [RamDataSize-1:0] mask_line;
    logic [1:0]             mask_idx;
    logic [BValSize-1:0]    mask_b_val;
    logic [CpuDataSize-1:0] masked_word;
    logic                   mask_err;
    logic                   unused_offset_bits;

    assign unused_offset_bits = ^IN_ADDR_OFFSET[1:0];

    // A hit is masked straight from the request inputs; a fill uses the latched selection.
    always_comb begin
        if (state_q == StIdle) begin
            mask_line  = IN_CACHE_DATA;
            mask_idx   = IN_ADDR_OFFSET[3:2];
            mask_b_val = IN_B_VAL;
        end else begin
            mask_line  = IN_RAM_DATA;
            mask_idx   = idx_q;
            mask_b_val = b_val_q;
        end
    end

    cache_read_responder_read_word_mask u_read_word_mask (
        .line     (mask_line),
        .word_idx (mask_idx),
        .b_val    (mask_b_val),
        .word     (masked_word),
        .err      (mask_err)
    );

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        fill_data_d  = fill_data_q;
        fill_valid_d = 1'b0;
        idx_d        = idx_q;
        b_val_d      = b_val_q;
        cnt_d        = cnt_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            StIdle: begin
                if (IN_REQ_VALID) begin
                    idx_d   = IN_ADDR_OFFSET[3:2];
                    b_val_d = IN_B_VAL;
                    if (IN_HIT) begin
                        line_d      = IN_CACHE_DATA;
                        resp_data_d = masked_word;
                        resp_err_d  = mask_err;
                        state_d     = StResp;
                    end else begin
                        cnt_d   = '0;
                        state_d = StWaitRam;
                    end
                end
            end
            StWaitRam: begin
                cnt_d = cnt_q + 1'b1;
                // Returned data takes priority over a timeout in the same cycle.
                if (IN_RAM_VALID) begin
                    line_d       = IN_RAM_DATA;
                    fill_data_d  = IN_RAM_DATA;
                    fill_valid_d = 1'b1;
                    resp_data_d  = masked_word;
                    resp_err_d   = mask_err;
                    state_d      = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (IN_RESP_READY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            line_q       <= '0;
            fill_data_q  <= '0;
            fill_valid_q <= 1'b0;
            idx_q        <= '0;
            b_val_q      <= '0;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            fill_data_q  <= fill_data_d;
            fill_valid_q <= fill_valid_d;
            idx_q        <= idx_d;
            b_val_q      <= b_val_d;
            cnt_q        <= cnt_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Ready is gated by reset so it is low for the whole time reset is held.
    assign OUT_REQ_READY  = RST_N && (state_q == StIdle);
    assign OUT_RAM_REQ    = (state_q == StWaitRam);
    assign OUT_RESP_VALID = (state_q == StResp);
    assign OUT_FILL_VALID = fill_valid_q;
    assign OUT_FILL_DATA  = fill_data_q;
    assign OUT_RESP_DATA  = resp_data_q;
    assign OUT_RESP_ERR   = resp_err_q;

endmodule

// File: tb/tb_cache_read_responder.sv
// Randomized self-checking bench for cache_read_responder against a behavioural model.
module tb_cache_read_responder;

    localparam int Timeout = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         hit = 1'b0;
    logic [3:0]   offset = '0;
    logic [3:0]   b_val = '0;
    logic [127:0] cache_data = '0;
    logic         ram_req;
    logic         ram_valid = 1'b0;
    logic [127:0] ram_data = '0;
    logic         fill_valid;
    logic [127:0] fill_data;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [31:0]  resp_data;
    logic         resp_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_read_responder #(.TIMEOUT_CYCLES(Timeout)) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .IN_REQ_VALID   (req_valid),
        .OUT_REQ_READY  (req_ready),
        .IN_HIT         (hit),
        .IN_ADDR_OFFSET (offset),
        .IN_B_VAL       (b_val),
        .IN_CACHE_DATA  (cache_data),
        .OUT_RAM_REQ    (ram_req),
        .IN_RAM_VALID   (ram_valid),
        .IN_RAM_DATA    (ram_data),
        .OUT_FILL_VALID (fill_valid),
        .OUT_FILL_DATA  (fill_data),
        .OUT_RESP_VALID (resp_valid),
        .IN_RESP_READY  (resp_ready),
        .OUT_RESP_DATA  (resp_data),
        .OUT_RESP_ERR   (resp_err)
    );

    // Reference: pick word offset[3:2], keep enabled lanes, illegal enables give 0 + error.
    function automatic void model(input logic [127:0] line, input logic [3:0] off,
                                  input logic [3:0] bv, output logic [31:0] data,
                                  output logic err);
        logic [3:0]   legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1111};
        logic [127:0] shifted;
        logic [31:0]  w;
        err = 1'b1;
        foreach (legal[i]) if (bv == legal[i]) err = 1'b0;
        shifted = line >> (32 * int'(off[3:2]));
        w = shifted[31:0];
        data = '0;
        for (int k = 0; k < 4; k++) if (bv[k]) data[8*k +: 8] = w[8*k +: 8];
        if (err) data = '0;
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [3:0] rand_b_val();
        logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0011, 4'b1100, 4'b1111};
        if ($urandom_range(0, 3) != 0) return legal[$urandom_range(0, 6)];
        return 4'($urandom);
    endfunction

    // Drives one request at a negedge and returns at the following negedge.
    task automatic send_req(input logic h, input logic [3:0] off, input logic [3:0] bv,
                            input logic [127:0] line);
        @(negedge clk);
        req_valid = 1'b1; hit = h; offset = off; b_val = bv; cache_data = line;
        @(negedge clk);
        req_valid = 1'b0; hit = $urandom_range(0, 1); cache_data = rand_line();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({req_ready, ram_req, fill_valid, resp_valid, resp_err} !== 5'b0 ||
            resp_data !== '0 || fill_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%b ramreq=%b fill=%b vld=%b err=%b data=%h, want all 0",
                     req_ready, ram_req, fill_valid, resp_valid, resp_err, resp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: rdy=%b vld=%b, want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_hit();
        send_req(1'b1, 4'b1000, 4'b1111, 128'h44444444_33333333_22222222_11111111);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h33333333 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL hit_resp: vld=%b data=%h err=%b, want 1 33333333 0",
                     resp_valid, resp_data, resp_err);
        end
        checks++;
        if (ram_req !== 1'b0 || fill_valid !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL hit_side: ramreq=%b fill=%b rdy=%b, want 0 0 0",
                     ram_req, fill_valid, req_ready);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL hit_done: vld=%b rdy=%b, want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_miss();
        logic [127:0] line = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        int req_cycles = 0;
        send_req(1'b0, 4'b1100, 4'b1100, rand_line());
        for (int c = 1; c <= 5; c++) begin
            if (ram_req === 1'b1) req_cycles++;
            if (c == 5) begin
                ram_valid = 1'b1; ram_data = line;
            end
            @(negedge clk);
        end
        ram_valid = 1'b0; ram_data = rand_line();
        checks++;
        if (req_cycles != 5 || ram_req !== 1'b0) begin
            failures++;
            $display("FAIL miss_ram_req: high_cycles=%0d after=%b, want 5 0", req_cycles, ram_req);
        end
        checks++;
        if (fill_valid !== 1'b1 || fill_data !== line) begin
            failures++;
            $display("FAIL miss_fill: fill=%b data=%h, want 1 %h", fill_valid, fill_data, line);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD0000 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL miss_resp: vld=%b data=%h err=%b, want 1 dead0000 0",
                     resp_valid, resp_data, resp_err);
        end
        @(negedge clk);
        checks++;
        if (fill_valid !== 1'b0 || resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL miss_fill_pulse: fill=%b vld=%b, want 0 1", fill_valid, resp_valid);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_illegal();
        send_req(1'b1, 4'b0100, 4'b0101, rand_line());
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_bval: vld=%b data=%h err=%b, want 1 0 1",
                     resp_valid, resp_data, resp_err);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL illegal_idle: vld=%b rdy=%b, want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] line = rand_line();
        logic [3:0]   off = 4'($urandom);
        logic [31:0]  exp_data;
        logic         exp_err;
        model(line, off, 4'b1111, exp_data, exp_err);
        send_req(1'b1, off, 4'b1111, line);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_err !== exp_err ||
                req_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: vld=%b data=%h err=%b rdy=%b, want 1 %h %b 0",
                         i, resp_valid, resp_data, resp_err, req_ready, exp_data, exp_err);
            end
            req_valid = $urandom_range(0, 1);
            hit = 1'b1; cache_data = rand_line(); ram_valid = $urandom_range(0, 1);
            @(negedge clk);
        end
        req_valid = 1'b0; ram_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || fill_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: vld=%b rdy=%b fill=%b, want 0 1 0",
                     resp_valid, req_ready, fill_valid);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        send_req(1'b0, 4'b0000, 4'b1111, rand_line());
        n = 1;
        while (resp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n - 1 != Timeout) begin
            failures++;
            $display("FAIL timeout_latency: cycles=%0d, want %0d", n - 1, Timeout);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_err !== 1'b1 ||
            fill_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_resp: vld=%b data=%h err=%b fill=%b, want 1 0 1 0",
                     resp_valid, resp_data, resp_err, fill_valid);
        end
        ram_valid = 1'b1; ram_data = rand_line();
        repeat (2) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        @(negedge clk);
        ram_valid = 1'b0;
        checks++;
        if (fill_valid !== 1'b0 || resp_valid !== 1'b0 || ram_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_late_ram: fill=%b vld=%b ramreq=%b, want 0 0 0",
                     fill_valid, resp_valid, ram_req);
        end
    endtask

    task automatic test_reset_mid();
        send_req(1'b0, 4'b0100, 4'b0011, rand_line());
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, ram_req, fill_valid, resp_valid, resp_err} !== 5'b0 ||
            resp_data !== '0 || fill_data !== '0) begin
            failures++;
            $display("FAIL reset_mid: rdy=%b ramreq=%b fill=%b vld=%b err=%b, want all 0",
                     req_ready, ram_req, fill_valid, resp_valid, resp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ram_valid = 1'b1; ram_data = rand_line();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fill_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_stale_ram[%0d]: fill=%b vld=%b rdy=%b, want 0 0 1",
                         i, fill_valid, resp_valid, req_ready);
            end
        end
        ram_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic         h = 1'($urandom_range(0, 1));
            logic [3:0]   off = 4'($urandom);
            logic [3:0]   bv = rand_b_val();
            logic [127:0] line = rand_line();
            logic [31:0]  exp_data;
            logic         exp_err;
            int           d = $urandom_range(1, 8);
            int           r = $urandom_range(0, 3);
            model(line, off, bv, exp_data, exp_err);
            send_req(h, off, bv, h ? line : rand_line());
            if (!h) begin
                for (int c = 1; c < d; c++) @(negedge clk);
                ram_valid = 1'b1; ram_data = line;
                @(negedge clk);
                ram_valid = 1'b0; ram_data = rand_line();
            end
            checks++;
            if (fill_valid !== !h || (!h && fill_data !== line)) begin
                failures++;
                $display("FAIL rand_fill[%0d]: fill=%b data=%h, want %b %h",
                         t, fill_valid, fill_data, !h, line);
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_err !== exp_err) begin
                failures++;
                $display("FAIL rand_resp[%0d]: vld=%b data=%h err=%b, want 1 %h %b",
                         t, resp_valid, resp_data, resp_err, exp_data, exp_err);
            end
            repeat (r) @(negedge clk);
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand_done[%0d]: vld=%b rdy=%b, want 0 1", t, resp_valid, req_ready);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_illegal();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
